// File: rtl/hazard_fwd_unit.sv
// Purpose: RAW hazard detection, EX operand forwarding selects and branch flush for the 5-stage MIPS pipeline.
// Latency: stall/flush/fwd_* are combinational in the current cycle; scoreboard and counters update on the rising edge.
// Backpressure: stall holds PC and IF/ID and bubbles EX; flush squashes IF/ID and ID; flush overrides stall.
//
// Ports:
//   clock_in, reset         rising-edge clock, synchronous active-high reset
//   id_*                    ID-stage decode fields (valid, sources, use bits, destination, write/load flags)
//   ex_branch_taken         branch or jump resolved taken in EX this cycle
//   fwd_a, fwd_b            EX operand select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data
//   stall, flush            pipeline hold / squash controls
//   stall_cnt, flush_cnt    saturating event counters
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // One scoreboard entry per downstream stage.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              reg_write;
        logic              mem_read;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              uses_rs;
        logic              uses_rt;
    } slot_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    slot_t ex_q, mem_q, wb_q;
    slot_t ex_d, mem_d, wb_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic raw_stall;
    logic stall_int;
    logic flush_int;

    // A slot produces a value the consumer needs. The consumer's use bit is
    // passed in so a field that merely decodes to a register number but is
    // not read (e.g. lw's rt) cannot create a false hazard. $0 never hazards.
    function automatic logic slot_match(input slot_t s,
                                        input logic [REG_AW-1:0] r,
                                        input logic uses);
        return s.valid && s.reg_write && (s.dst == r) && (r != '0) && uses;
    endfunction

    // Forward select for one EX operand. The MEM producer is younger than
    // the WB producer, so it wins. A load in MEM has no data yet; the
    // load-use stall keeps that case from reaching EX with forwarding on.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r,
                                           input logic uses);
        logic [1:0] sel;
        sel = SEL_RF;
        if (slot_match(mem_q, r, uses) && !mem_q.mem_read) begin
            sel = SEL_MEM;
        end else if (slot_match(wb_q, r, uses)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Hazard detection.
    always_comb begin
        raw_stall = 1'b0;
        if (FWD_EN) begin
            // Only a load in EX cannot be bypassed in time: one bubble.
            raw_stall = id_valid && ex_q.mem_read &&
                        (slot_match(ex_q, id_rs, id_uses_rs) ||
                         slot_match(ex_q, id_rt, id_uses_rt));
        end else begin
            // Without bypass paths the consumer waits until the producer
            // has left WB (register file written in WB, read next cycle).
            raw_stall = id_valid &&
                        (slot_match(ex_q,  id_rs, id_uses_rs) ||
                         slot_match(ex_q,  id_rt, id_uses_rt) ||
                         slot_match(mem_q, id_rs, id_uses_rs) ||
                         slot_match(mem_q, id_rt, id_uses_rt) ||
                         slot_match(wb_q,  id_rs, id_uses_rs) ||
                         slot_match(wb_q,  id_rt, id_uses_rt));
        end
    end

    // A taken branch kills the ID instruction anyway, so stalling it is moot.
    assign flush_int = ex_branch_taken;
    assign stall_int = raw_stall && !ex_branch_taken;

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        flush = 1'b0;
        stall = 1'b0;
        fwd_a = SEL_RF;
        fwd_b = SEL_RF;
        if (!reset) begin
            flush = flush_int;
            stall = stall_int;
            if (FWD_EN && ex_q.valid) begin
                fwd_a = fwd_sel(ex_q.rs, ex_q.uses_rs);
                fwd_b = fwd_sel(ex_q.rt, ex_q.uses_rt);
            end
        end
    end

    // Scoreboard advance. Bubbles are written as all-zero so a squashed or
    // held instruction leaves no stale use bits behind in EX.
    always_comb begin
        mem_d = ex_q;
        wb_d  = mem_q;
        ex_d  = '0;
        if (!flush_int && !stall_int && id_valid) begin
            ex_d.valid     = 1'b1;
            ex_d.dst       = id_dst;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.uses_rs   = id_uses_rs;
            ex_d.uses_rt   = id_uses_rt;
        end
    end

    // Saturating statistics counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_int && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_int && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Source fields of the older slots are carried for visibility only;
    // hazard checks never look at them.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{mem_q.rs, mem_q.rt, mem_q.uses_rs, mem_q.uses_rt,
                                wb_q.mem_read, wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, ex_branch_taken;
    logic [4:0] id_rs, id_rt, id_dst;

    logic [1:0]  fa_f, fb_f, fa_n, fb_n;
    logic        st_f, fl_f, st_n, fl_n;
    logic [1:0]  sc_f, fc_f;
    logic [15:0] sc_n, fc_n;

    // dut 0: forwarding, 2-bit counters (saturation reachable)
    hazard_fwd_unit #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(2)) u_f (
        .clock_in(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a(fa_f), .fwd_b(fb_f), .stall(st_f), .flush(fl_f),
        .stall_cnt(sc_f), .flush_cnt(fc_f)
    );

    // dut 1: no forwarding, default counters
    hazard_fwd_unit #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(16)) u_n (
        .clock_in(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a(fa_n), .fwd_b(fb_n), .stall(st_n), .flush(fl_n),
        .stall_cnt(sc_n), .flush_cnt(fc_n)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs, rt, dst;
        logic       urs, urt, rw, mr;
    } ins_t;

    typedef struct {
        int    dut;
        int    fa, fb, st, fl;
        bit    chk_cnt;
        int    sc, fc;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic ins_t rtype(input int d, input int s, input int t);
        ins_t i;
        i.v = 1'b1; i.rs = 5'(s); i.rt = 5'(t); i.dst = 5'(d);
        i.urs = 1'b1; i.urt = 1'b1; i.rw = 1'b1; i.mr = 1'b0;
        return i;
    endfunction

    function automatic ins_t lw(input int d, input int base);
        ins_t i;
        i.v = 1'b1; i.rs = 5'(base); i.rt = 5'(d); i.dst = 5'(d);
        i.urs = 1'b1; i.urt = 1'b0; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic ins_t nop();
        ins_t i;
        i = '0;
        return i;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show in it.
    task automatic cyc(input int dut, input ins_t i, input logic br, input logic rst,
                       input int fa, input int fb, input int st, input int fl,
                       input bit chk_cnt, input int sc, input int fc, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        id_valid        = i.v;
        id_rs           = i.rs;
        id_rt           = i.rt;
        id_dst          = i.dst;
        id_uses_rs      = i.urs;
        id_uses_rt      = i.urt;
        id_reg_write    = i.rw;
        id_mem_read     = i.mr;
        ex_branch_taken = br;
        e.dut = dut; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl;
        e.chk_cnt = chk_cnt; e.sc = sc; e.fc = fc; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int dut, input string name);
        cyc(dut, rtype(3, 3, 3), 1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 0, 0, {name, "_rst_hold"});
        cyc(dut, nop(),          1'b0, 1'b1, 0, 0, 0, 0, 1'b1, 0, 0, {name, "_rst_state"});
    endtask

    // Monitor: outputs are combinational and valid every cycle, so one
    // queued expectation is consumed per cycle at the falling edge.
    exp_t        mon_e;
    logic [31:0] a_fa, a_fb, a_st, a_fl, a_sc, a_fc;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.dut == 0) begin
                a_fa = 32'(fa_f); a_fb = 32'(fb_f); a_st = 32'(st_f); a_fl = 32'(fl_f);
                a_sc = 32'(sc_f); a_fc = 32'(fc_f);
            end else begin
                a_fa = 32'(fa_n); a_fb = 32'(fb_n); a_st = 32'(st_n); a_fl = 32'(fl_n);
                a_sc = 32'(sc_n); a_fc = 32'(fc_n);
            end
            chk({mon_e.name, ".fwd_a"}, a_fa, mon_e.fa);
            chk({mon_e.name, ".fwd_b"}, a_fb, mon_e.fb);
            chk({mon_e.name, ".stall"}, a_st, mon_e.st);
            chk({mon_e.name, ".flush"}, a_fl, mon_e.fl);
            if (mon_e.chk_cnt) begin
                chk({mon_e.name, ".stall_cnt"}, a_sc, mon_e.sc);
                chk({mon_e.name, ".flush_cnt"}, a_fc, mon_e.fc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dst = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        ex_branch_taken = 1'b0;

        // add $3,$1,$2 ; sub $4,$3,$5 back to back -> EX/MEM bypass on rs
        do_reset(0, "fwd");
        cyc(0, rtype(3, 1, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "fwd_add");
        cyc(0, rtype(4, 3, 5), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "fwd_sub_in_id");
        cyc(0, nop(),          1'b0, 1'b0, 1, 0, 0, 0, 1'b1, 0, 0, "fwd_sub_ex_mem");
        cyc(0, nop(),          1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "fwd_bubble");

        // one independent instruction in between -> MEM/WB bypass
        do_reset(0, "fwdwb");
        cyc(0, rtype(3, 1, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "fwdwb_add");
        cyc(0, rtype(7, 8, 9), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "fwdwb_or");
        cyc(0, rtype(4, 3, 5), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "fwdwb_sub_in_id");
        cyc(0, nop(),          1'b0, 1'b0, 2, 0, 0, 0, 1'b1, 0, 0, "fwdwb_sub_ex");

        // rs from WB, rt from MEM in the same cycle
        do_reset(0, "mix");
        cyc(0, rtype(3, 1, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "mix_add3");
        cyc(0, rtype(6, 7, 8), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "mix_add6");
        cyc(0, rtype(9, 3, 6), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "mix_sub_in_id");
        cyc(0, nop(),          1'b0, 1'b0, 2, 1, 0, 0, 1'b1, 0, 0, "mix_sub_ex");

        // two writers of $3: the younger (MEM) wins over WB
        do_reset(0, "prio");
        cyc(0, rtype(3, 1, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "prio_add_a");
        cyc(0, rtype(3, 1, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "prio_add_b");
        cyc(0, rtype(4, 3, 5), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "prio_sub_in_id");
        cyc(0, nop(),          1'b0, 1'b0, 1, 0, 0, 0, 1'b1, 0, 0, "prio_sub_ex");

        // lw $2,0($1) ; add $4,$2,$2 -> one stall, then WB bypass on both
        do_reset(0, "lu");
        cyc(0, lw(2, 1),       1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "lu_lw");
        cyc(0, rtype(4, 2, 2), 1'b0, 1'b0, 0, 0, 1, 0, 1'b1, 0, 0, "lu_stall");
        cyc(0, rtype(4, 2, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1, 0, "lu_release");
        cyc(0, nop(),          1'b0, 1'b0, 2, 2, 0, 0, 1'b1, 1, 0, "lu_add_ex");
        cyc(0, nop(),          1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1, 0, "lu_drain");

        // register zero never hazards (both modes)
        do_reset(0, "rz");
        cyc(0, rtype(0, 1, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "rz_prod");
        cyc(0, rtype(4, 0, 0), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "rz_cons_id");
        cyc(0, nop(),          1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "rz_cons_ex");
        do_reset(1, "rzn");
        cyc(1, rtype(0, 1, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "rzn_prod");
        cyc(1, rtype(4, 0, 0), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "rzn_cons_id");

        // no forwarding: add $3 ; or $6,$3,$0 -> 3 stall cycles
        do_reset(1, "nf");
        cyc(1, rtype(3, 1, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "nf_add");
        cyc(1, rtype(6, 3, 0), 1'b0, 1'b0, 0, 0, 1, 0, 1'b1, 0, 0, "nf_stall_ex");
        cyc(1, rtype(6, 3, 0), 1'b0, 1'b0, 0, 0, 1, 0, 1'b1, 1, 0, "nf_stall_mem");
        cyc(1, rtype(6, 3, 0), 1'b0, 1'b0, 0, 0, 1, 0, 1'b1, 2, 0, "nf_stall_wb");
        cyc(1, rtype(6, 3, 0), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3, 0, "nf_proceed");
        cyc(1, nop(),          1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3, 0, "nf_or_ex");

        // flush beats a simultaneous load-use stall; squashed add never enters
        do_reset(0, "fl");
        cyc(0, lw(2, 1),       1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "fl_lw");
        cyc(0, rtype(4, 2, 2), 1'b1, 1'b0, 0, 0, 0, 1, 1'b1, 0, 0, "fl_beats_stall");
        cyc(0, rtype(5, 4, 4), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 1, "fl_target");
        cyc(0, nop(),          1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 1, "fl_no_fwd_squashed");

        // five load-use stalls into a 2-bit counter -> saturates at 3
        do_reset(0, "sat");
        for (int k = 0; k < 5; k++) begin
            cyc(0, lw(2, 1), 1'b0, 1'b0, (k == 0) ? 0 : 2, (k == 0) ? 0 : 2, 0, 0,
                1'b1, (k < 3) ? k : 3, 0, $sformatf("sat%0d_lw", k));
            cyc(0, rtype(4, 2, 2), 1'b0, 1'b0, 0, 0, 1, 0,
                1'b1, (k < 3) ? k : 3, 0, $sformatf("sat%0d_stall", k));
            cyc(0, rtype(4, 2, 2), 1'b0, 1'b0, 0, 0, 0, 0,
                1'b1, (k + 1 < 3) ? k + 1 : 3, 0, $sformatf("sat%0d_release", k));
        end

        // reset for one cycle exactly where a stall (and a flush) would occur
        cyc(0, lw(2, 1),       1'b0, 1'b0, 2, 2, 0, 0, 1'b1, 3, 0, "rst_pre_lw");
        cyc(0, rtype(4, 2, 2), 1'b1, 1'b1, 0, 0, 0, 0, 1'b1, 3, 0, "rst_midstall");
        cyc(0, rtype(4, 2, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "rst_cleared");
        cyc(0, nop(),          1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0, 0, "rst_slots_invalid");

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
